mux_4_by_1_rr_arbiter: RTL and testbench
========================================

Name: mux_4_by_1_rr_arbiter

Overview:
- Shares one 4x1 data multiplexer between four requesters using round-robin arbitration with a bounded hold (burst lock).
- Drives the mux select and captures the selected word into one output register.
- The output register has a valid/ready handshake towards a single consumer.
- Sits in front of the 4x1 multiplexer datapath as its select controller; one beat per cycle at full throughput.

Parameters:
- DATA_W, 8: width of each requester data word and of out_mux.
- MAX_HOLD, 4: maximum consecutive beats granted to one requester while another requester is waiting. Legal range 1..15.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req_mux, input, 4: request vector; bit i set means requester i+1 has a word on in_mux_(i+1).
- in_mux_1, input, DATA_W: data from requester 1 (req_mux[0]).
- in_mux_2, input, DATA_W: data from requester 2 (req_mux[1]).
- in_mux_3, input, DATA_W: data from requester 3 (req_mux[2]).
- in_mux_4, input, DATA_W: data from requester 4 (req_mux[3]).
- gnt_mux, output, 4: one-hot, combinational; bit i means requester i's word is captured this cycle, and the requester advances or drops its request next cycle.
- sel_mux, output, 2: registered index of the requester whose word is held in out_mux.
- out_valid, output, 1: out_mux holds a valid word.
- out_ready, input, 1: consumer accepts out_mux this cycle.
- out_mux, output, DATA_W: registered output word.

Behaviour:
- Reset, while rst=1 at a clock edge:
  - out_valid=0, out_mux=0, sel_mux=0.
  - Pointer=3, so requester 1 has first priority.
  - owner_vld=0, hold_cnt=0.
  - gnt_mux is forced to 0 during any cycle with rst=1.
- Capture condition: load = (|req_mux) & (!out_valid | out_ready) & !rst.
  - gnt_mux is nonzero only when load=1.
- On load, at the clock edge:
  - out_mux <= in_mux_(w+1), sel_mux <= w, out_valid <= 1, pointer <= w.
- On out_valid & out_ready & !load: out_valid <= 0. out_mux and sel_mux keep their values.
- Stall (out_valid=1, out_ready=0): gnt_mux=0; out_mux and sel_mux stay stable until accepted.
- Latency: word visible on out_mux one cycle after its gnt. Back-to-back loads give one beat per cycle.
- Winner w selection (FSM states IDLE: owner_vld=0, LOCKED: owner_vld=1 with owner=pointer):
  - LOCKED, req_mux[owner]=1, hold_cnt<MAX_HOLD: w=owner, hold_cnt++.
  - LOCKED with hold_cnt=MAX_HOLD, or owner not requesting: round-robin search from owner+1 mod 4 upward.
    - The first requesting index wins.
    - If that index is the owner itself (no other requester), hold_cnt restarts at 1.
    - Otherwise the state stays LOCKED with the new owner and hold_cnt=1.
  - IDLE: round-robin search from pointer+1 mod 4; go to LOCKED with hold_cnt=1.
  - LOCKED and req_mux=0 in a cycle where load would otherwise be possible: go to IDLE; the pointer is kept.
- Wrap-around: search order after index 3 is 0,1,2,3.
- Simultaneous accept and load: the new word replaces the old one; out_valid stays 1 with no bubble.
- Request changes during a stall are ignored until the capture cycle; arbitration uses req_mux in the load cycle only.
- Reset mid-operation: any held word is discarded with no grant; the next grant follows the reset priority.

Decomposition:
- Package mux_arb_pkg:
  - typedef state_t enum {IDLE, LOCKED}.
  - typedef idx_t logic [1:0].
  - Constant NUM_REQ=4.
  - Function rr_pick(req, start) returning idx_t.
- One sub-module, mux_4_by_1_case_reg: combinational 4x1 DATA_W-wide select plus the output register with its load enable. The arbiter FSM, hold counter and grant logic stay in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles, req_mux=0000 -> out_valid=0, out_mux=0, sel_mux=0, gnt_mux=0000 throughout.
- Fair rotation: all four request continuously, MAX_HOLD=1, out_ready=1, data 0x11/0x22/0x33/0x44 -> gnt sequence 0001,0010,0100,1000,0001; out_mux 0x11,0x22,0x33,0x44 on consecutive cycles, one cycle behind each gnt.
- Hold limit: MAX_HOLD=4, req_mux=0011 held, out_ready=1 -> requester 1 granted 4 consecutive cycles, then requester 2 granted 4 cycles, then back to requester 1.
- Lone requester: only req_mux[2] set for 10 cycles -> gnt_mux=0100 every cycle, no bubbles, sel_mux=2.
- Backpressure: out_ready=0 for 5 cycles after the first load with all requests high -> out_valid=1, out_mux and sel_mux stable, gnt_mux=0000. When out_ready rises, the next gnt appears in the same cycle.
- Reset mid-burst: rst asserted while out_valid=1 and owner=3 with hold_cnt=2 -> next cycle out_valid=0. After release with req_mux=1111, the first gnt is 0001.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types, constants and the round-robin search helper for the
// four-requester mux select arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;

    // IDLE: no current owner. LOCKED: the pointer names the current owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef logic [1:0] idx_t;

    // Round-robin search. It returns the first requesting index found when
    // scanning start+1, start+2, start+3, start (mod 4), so 'start' is the
    // lowest-priority candidate. The loop runs from the farthest offset to
    // the nearest, so the nearest requesting index is the last one written.
    // If nothing is requesting, 'start' is returned; callers only use the
    // result when at least one request is set.
    function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t start);
        idx_t pick;
        idx_t cand;
        pick = start;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = start + idx_t'(k);
            if (req[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4_by_1_case_reg.sv
// 4x1 data select followed by the output holding register with its
// valid/ready handshake. When load_i is set the selected word is captured.
// When the held word is accepted and nothing new is loaded, valid drops.
// The data and select values persist after acceptance.
module mux_4_by_1_case_reg
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] in_1_i,
    input  logic [DATA_W-1:0] in_2_i,
    input  logic [DATA_W-1:0] in_3_i,
    input  logic [DATA_W-1:0] in_4_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        sel_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] mux_d;
    logic [DATA_W-1:0] data_q;
    idx_t              sel_q;
    logic              valid_q;

    // Combinational 4x1 word select driven by the arbiter's winner index.
    always_comb begin
        mux_d = '0;
        case (sel_i)
            2'd0:    mux_d = in_1_i;
            2'd1:    mux_d = in_2_i;
            2'd2:    mux_d = in_3_i;
            default: mux_d = in_4_i;
        endcase
    end

    // Output register. A load overrides a simultaneous accept, so
    // back-to-back beats see no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= mux_d;
            sel_q   <= sel_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mux_4_by_1_rr_arbiter.sv
// Round-robin select controller for a shared 4x1 data mux, with burst lock.
// A requester that keeps requesting keeps the mux for up to MAX_HOLD
// consecutive beats. After that, the next requester in rotation takes over.
//
// Handshake: out_mux/sel_mux are valid while out_valid=1. A word transfers
// on a rising edge where out_valid=1 and out_ready=1. A new word is captured
// (gnt_mux nonzero) only when some request is set and the register is
// empty or being drained in the same cycle.
// Requesters see their grant combinationally in the capture cycle.
module mux_4_by_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_mux,
    input  logic [DATA_W-1:0] in_mux_1,
    input  logic [DATA_W-1:0] in_mux_2,
    input  logic [DATA_W-1:0] in_mux_3,
    input  logic [DATA_W-1:0] in_mux_4,
    output logic [3:0]        gnt_mux,
    output logic [1:0]        sel_mux,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mux
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    // The pointer is the last winner. While LOCKED it is also the owner.
    state_t     state_q, state_d;
    idx_t       ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;

    logic       can_take;
    logic       load;
    logic       keep_owner;
    idx_t       win;

    // The register can take a word when it is empty or being drained.
    // Reset blocks all grants.
    assign can_take = (!out_valid || out_ready) && !rst;
    assign load     = (|req_mux) && can_take;

    // The owner may continue its burst while it requests and has beats left.
    assign keep_owner = (state_q == LOCKED) && req_mux[ptr_q] && (hold_q < HOLD_MAX);

    // Pick the winner and compute the next arbitration state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        win     = keep_owner ? ptr_q : rr_pick(req_mux, ptr_q);
        if (load) begin
            state_d = LOCKED;
            ptr_d   = win;
            // A fresh burst, including the owner re-winning an empty
            // rotation, restarts the count at one beat.
            hold_d  = keep_owner ? (hold_q + 4'd1) : 4'd1;
        end else if (can_take) begin
            // Capture was possible but nobody asked: release ownership and
            // keep the pointer so rotation continues from the last winner.
            state_d = IDLE;
        end
    end

    // Arbitration state. After reset the pointer is 3, so requester 1 is
    // searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_mux = load ? (4'b0001 << win) : 4'b0000;

    mux_4_by_1_case_reg #(
        .DATA_W (DATA_W)
    ) u_case_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .sel_i   (win),
        .in_1_i  (in_mux_1),
        .in_2_i  (in_mux_2),
        .in_3_i  (in_mux_3),
        .in_4_i  (in_mux_4),
        .ready_i (out_ready),
        .data_o  (out_mux),
        .sel_o   (sel_mux),
        .valid_o (out_valid)
    );

endmodule

// File: tb/tb_mux_4_by_1_rr_arbiter.sv
// Bench for mux_4_by_1_rr_arbiter.
// The driver applies one input vector per cycle and predicts the grant from
// a behavioural arbitration model. Each captured word is queued for the
// output monitor, which checks the output register independently.
module tb_mux_4_by_1_rr_arbiter;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int W        = 2 + DATA_W;

  logic              clk;
  logic              rst;
  logic [3:0]        req_mux;
  logic [DATA_W-1:0] in_mux_1, in_mux_2, in_mux_3, in_mux_4;
  logic [3:0]        gnt_mux;
  logic [1:0]        sel_mux;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mux;

  mux_4_by_1_rr_arbiter #(
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_mux   (req_mux),
    .in_mux_1  (in_mux_1),
    .in_mux_2  (in_mux_2),
    .in_mux_3  (in_mux_3),
    .in_mux_4  (in_mux_4),
    .gnt_mux   (gnt_mux),
    .sel_mux   (sel_mux),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mux   (out_mux)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {sel, data} of words expected in the output register
  logic [W-1:0] exp_q[$];
  int           vectors    = 0;
  int           miscompares = 0;
  bit           mon_en     = 0;

  // capture from the current cycle, which becomes visible after the next edge
  bit           push_pend  = 0;
  bit           clr_pend   = 0;
  logic [W-1:0] pend_item;

  // reference model: last winner, whether someone owns the mux, burst length, output-full
  int m_last  = 3;
  bit m_owned = 0;
  int m_burst = 0;
  bit m_full  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // driver: one cycle of stimulus plus the grant prediction
  task automatic step(input logic r, input logic [3:0] rq, input logic rdy,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] dv[4];
    logic [3:0] exp_gnt;
    logic [1:0] wi;
    bit         ld;
    int         w;
    @(negedge clk);
    if (clr_pend) begin
      exp_q.delete();
      clr_pend = 0;
    end else if (push_pend) begin
      exp_q.push_back(pend_item);
      push_pend = 0;
    end
    rst = r; req_mux = rq; out_ready = rdy;
    in_mux_1 = a; in_mux_2 = b; in_mux_3 = c; in_mux_4 = d;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    #1;
    ld = (rq != 4'b0000) && (!m_full || rdy) && !r;
    exp_gnt = 4'b0000;
    if (ld) begin
      if (m_owned && rq[m_last] && m_burst < MAX_HOLD) begin
        w = m_last;
        m_burst = m_burst + 1;
      end else begin
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && rq[(m_last + k) % 4]) w = (m_last + k) % 4;
        m_burst = 1;
      end
      m_owned = 1;
      m_last = w;
      wi = w[1:0];
      exp_gnt = 4'b0001 << wi;
      pend_item = {wi, dv[w]};
      push_pend = 1;
    end else if (!r && (!m_full || rdy)) begin
      m_owned = 0;
    end
    if (r) m_full = 0;
    else if (ld) m_full = 1;
    else if (rdy) m_full = 0;
    if (r) begin
      m_last = 3; m_owned = 0; m_burst = 0;
      clr_pend = 1; push_pend = 0;
    end
    check("gnt_mux", {28'd0, gnt_mux}, {28'd0, exp_gnt});
  endtask

  // monitor: checks the output register against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
        if (out_valid && exp_q.size() != 0) begin
          check("out_word", {22'd0, sel_mux, out_mux}, {22'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] rr;
    rst = 1'b1; req_mux = '0; out_ready = 1'b0;
    in_mux_1 = '0; in_mux_2 = '0; in_mux_3 = '0; in_mux_4 = '0;

    // reset then idle
    step(1, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    mon_en = 1;
    step(1, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    step(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_mux", {24'd0, out_mux}, 32'd0);
    check("reset sel_mux", {30'd0, sel_mux}, 32'd0);
    step(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);

    // rotation, all requesting
    for (int i = 0; i < 20; i++) step(0, 4'b1111, 1, 8'h11, 8'h22, 8'h33, 8'h44);

    // hold limit with two requesters
    for (int i = 0; i < 18; i++) step(0, 4'b0011, 1, 8'h11, 8'h22, 8'h33, 8'h44);

    // lone requester
    for (int i = 0; i < 10; i++) step(0, 4'b0100, 1, 8'h11, 8'h22, 8'h33, 8'h44);

    // backpressure: stall five cycles with changing requests, then release
    step(0, 4'b1111, 1, 8'h55, 8'h66, 8'h77, 8'h88);
    for (int i = 0; i < 5; i++) step(0, 4'(i + 3), 0, 8'h01, 8'h02, 8'h03, 8'h04);
    for (int i = 0; i < 4; i++) step(0, 4'b1111, 1, 8'h91, 8'h92, 8'h93, 8'h94);

    // reset mid-burst with requester 4 owning two beats
    step(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    step(0, 4'b1000, 1, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    step(0, 4'b1000, 1, 8'hA1, 8'hA2, 8'hA3, 8'hB4);
    step(1, 4'b1111, 1, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    for (int i = 0; i < 4; i++) step(0, 4'b1111, 1, 8'hD1, 8'hD2, 8'hD3, 8'hD4);

    // randomized traffic with occasional reset and backpressure
    for (int i = 0; i < 800; i++) begin
      rr = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 63) == 0), rr, ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // drain
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
